// File: rtl/capture_analog_pkg.sv
// capture_analog_pkg
//   Shared types and sizing helpers for the triggered capture block.
//   - state_t      : capture state machine encoding
//   - SAMPLE_CNT_W : width of the shared sample/handshake counter
//   - ptr_width()  : address width for a DEPTH-entry ring buffer
package capture_analog_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_ARMED = 3'd2,
    ST_POST  = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  // Wide enough to count up to DEPTH for any buffer up to 64k samples.
  localparam int SAMPLE_CNT_W = 17;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/capture_ring_mem.sv
// capture_ring_mem
//   Simple dual-port DEPTH x WIDTH sample store. One write port, one
//   registered read port, no reset (maps onto block RAM).
// Ports:
//   clk     : clock
//   wr_en   : write strobe
//   wr_addr : write address
//   wr_data : write data
//   rd_en   : read enable; rd_data holds its value while low
//   rd_addr : read address
//   rd_data : registered read data
module capture_ring_mem
  import capture_analog_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 64
) (
  input  logic                        clk,
  input  logic                        wr_en,
  input  logic [ptr_width(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]            wr_data,
  input  logic                        rd_en,
  input  logic [ptr_width(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]            rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/capture_analog.sv
// capture_analog
//   Pre/post-trigger capture of a decimated signed sample stream into a
//   ring buffer, followed by an oldest-first valid/ready dump.
// Ports:
//   clk        : clock (rising edge)
//   rst_n      : asynchronous active-low reset, release synchronised
//   in         : input sample mantissa (signed)
//   level      : trigger threshold, same format as in
//   arm        : start one capture (IDLE only)
//   force_trig : trigger on the next strobe (ARMED only)
//   out        : dumped sample (0 when out_valid is low)
//   out_valid  : out holds a valid sample
//   out_ready  : downstream accepts out
//   busy       : high outside IDLE
//   done       : one-cycle pulse on the last accepted sample
module capture_analog
  import capture_analog_pkg::*;
#(
  parameter int IN_WIDTH    = 16,
  parameter int IN_EXPONENT = -12,
  parameter int DEPTH       = 64,
  parameter int PRE_TRIG    = 16,
  parameter int DECIM       = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic signed [IN_WIDTH-1:0] in,
  input  logic signed [IN_WIDTH-1:0] level,
  input  logic                       arm,
  input  logic                       force_trig,
  output logic signed [IN_WIDTH-1:0] out,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       busy,
  output logic                       done
);

  localparam int AW = ptr_width(DEPTH);
  localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;

  // in, level and out share one fixed-point format, so all arithmetic works
  // on raw mantissas. A configuration outside the supported range never
  // leaves IDLE rather than capturing garbage.
  localparam bit CFG_OK = (DEPTH >= 4) && ((DEPTH & (DEPTH - 1)) == 0) &&
                          (PRE_TRIG >= 1) && (PRE_TRIG <= DEPTH - 2) &&
                          (DECIM >= 1) && (DEPTH < (2 ** (SAMPLE_CNT_W - 1))) &&
                          (IN_EXPONENT >= -1022) && (IN_EXPONENT <= 1023);

  localparam logic [SAMPLE_CNT_W-1:0] PRE_LAST   = SAMPLE_CNT_W'(PRE_TRIG - 1);
  localparam logic [SAMPLE_CNT_W-1:0] POST_LAST  = SAMPLE_CNT_W'(DEPTH - PRE_TRIG - 1);
  localparam logic [SAMPLE_CNT_W-1:0] DRAIN_LAST = SAMPLE_CNT_W'(DEPTH - 1);
  localparam logic [SAMPLE_CNT_W-1:0] DEPTH_CNT  = SAMPLE_CNT_W'(DEPTH);
  localparam logic [DW-1:0]           DEC_LAST   = DW'(DECIM - 1);

  state_t                     state_reg, state_next;
  logic                       run_ok_reg;
  logic [AW-1:0]              wr_ptr_reg, rd_ptr_reg;
  logic [SAMPLE_CNT_W-1:0]    cnt_reg;
  logic [DW-1:0]              dec_reg;
  logic signed [IN_WIDTH-1:0] prev_reg;
  logic                       force_pend_reg;
  logic                       out_valid_reg;
  logic [IN_WIDTH-1:0]        rd_data;

  logic                    capturing, strobe, crossing, trig, hs, rd_en;
  logic                    pre_last, post_last, drain_last;
  logic [SAMPLE_CNT_W-1:0] issued;

  assign capturing  = (state_reg == ST_PRE) || (state_reg == ST_ARMED) ||
                      (state_reg == ST_POST);
  assign strobe     = capturing && (dec_reg == '0);
  assign crossing   = (prev_reg < level) && (in >= level);
  // A pending force, a same-cycle force and a crossing all collapse into
  // one trigger on the strobe.
  assign trig       = (state_reg == ST_ARMED) && strobe &&
                      (crossing || force_pend_reg || force_trig);
  assign hs         = out_valid_reg && out_ready;
  assign pre_last   = strobe && (cnt_reg == PRE_LAST);
  assign post_last  = strobe && (cnt_reg == POST_LAST);
  assign drain_last = hs && (cnt_reg == DRAIN_LAST);

  // Reads issued so far = accepted samples + the one currently presented.
  // A new read is launched when the output slot is empty or being taken,
  // giving one sample per clock and a frozen rd_data during stalls.
  assign issued = cnt_reg + SAMPLE_CNT_W'(out_valid_reg);
  assign rd_en  = (state_reg == ST_DRAIN) && (issued < DEPTH_CNT) &&
                  (!out_valid_reg || out_ready);

  // ---------------- state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE:  if (arm && run_ok_reg && CFG_OK) state_next = ST_PRE;
      ST_PRE:   if (pre_last)   state_next = ST_ARMED;
      ST_ARMED: if (trig)       state_next = ST_POST;
      ST_POST:  if (post_last)  state_next = ST_DRAIN;
      ST_DRAIN: if (drain_last) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // ---------------- outputs ----------------
  always_comb begin
    busy      = (state_reg != ST_IDLE);
    done      = (state_reg == ST_DRAIN) && drain_last;
    out_valid = out_valid_reg;
    // The RAM output is never reset, so mask it until a sample is valid.
    out       = out_valid_reg ? $signed(rd_data) : '0;
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_ok_reg     <= 1'b0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      cnt_reg        <= '0;
      dec_reg        <= '0;
      prev_reg       <= '0;
      force_pend_reg <= 1'b0;
      out_valid_reg  <= 1'b0;
    end else begin
      // Reset asserts asynchronously everywhere, but leaving IDLE waits for
      // this flag, so release is seen on a clean clock edge.
      run_ok_reg <= 1'b1;

      // Decimation phase is held at zero in IDLE, so the first clock after
      // arm is always a strobe.
      if (!capturing) begin
        dec_reg <= '0;
      end else if (dec_reg == DEC_LAST) begin
        dec_reg <= '0;
      end else begin
        dec_reg <= dec_reg + 1'b1;
      end

      if (strobe) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
        prev_reg   <= in;
      end

      force_pend_reg <= (state_reg == ST_ARMED) && !trig &&
                        (force_pend_reg || force_trig);

      unique case (state_reg)
        ST_IDLE:  cnt_reg <= '0;
        ST_PRE:   if (strobe) cnt_reg <= pre_last ? '0 : cnt_reg + 1'b1;
        // The trigger sample is the first of the post-trigger samples.
        ST_ARMED: if (trig) cnt_reg <= SAMPLE_CNT_W'(1);
        ST_POST:  if (strobe) cnt_reg <= post_last ? '0 : cnt_reg + 1'b1;
        ST_DRAIN: if (hs) cnt_reg <= drain_last ? '0 : cnt_reg + 1'b1;
        default:  cnt_reg <= '0;
      endcase

      // The final post-trigger write lands on this same edge, so the oldest
      // entry (wr_ptr - DEPTH) is one past the address being written.
      if ((state_reg == ST_POST) && post_last) begin
        rd_ptr_reg <= wr_ptr_reg + 1'b1;
      end else if (rd_en) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end

      if (rd_en) begin
        out_valid_reg <= 1'b1;
      end else if (hs) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  capture_ring_mem #(
    .WIDTH (IN_WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (strobe),
    .wr_addr (wr_ptr_reg),
    .wr_data (in),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr_reg),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_capture_analog.sv
// tb_capture_analog
//   Directed bench: two instances (DECIM=1 and DECIM=2) of an 8-deep,
//   3-pre-trigger capture with level=10.
module tb_capture_analog;

  localparam int W  = 16;
  localparam int D  = 8;
  localparam int PT = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic signed [W-1:0] in = '0;
  logic signed [W-1:0] level = 16'sd10;
  logic arm1 = 1'b0, arm2 = 1'b0, force_trig = 1'b0;
  logic rdy1 = 1'b0, rdy2 = 1'b0;
  logic signed [W-1:0] out1, out2;
  logic ov1, ov2, busy1, busy2, done1, done2;

  always #5 clk = ~clk;

  capture_analog #(.IN_WIDTH(W), .IN_EXPONENT(-12), .DEPTH(D), .PRE_TRIG(PT), .DECIM(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in(in), .level(level), .arm(arm1), .force_trig(force_trig),
    .out(out1), .out_valid(ov1), .out_ready(rdy1), .busy(busy1), .done(done1)
  );

  capture_analog #(.IN_WIDTH(W), .IN_EXPONENT(-12), .DEPTH(D), .PRE_TRIG(PT), .DECIM(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in(in), .level(level), .arm(arm2), .force_trig(force_trig),
    .out(out2), .out_valid(ov2), .out_ready(rdy2), .busy(busy2), .done(done2)
  );

  int checks = 0;
  int errors = 0;
  int sel = 0;
  int last_steps = 0;

  logic signed [W-1:0] o_out;
  logic o_valid, o_busy, o_done;
  assign o_out   = (sel == 1) ? out2  : out1;
  assign o_valid = (sel == 1) ? ov2   : ov1;
  assign o_busy  = (sel == 1) ? busy2 : busy1;
  assign o_done  = (sel == 1) ? done2 : done1;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rdy(input logic v);
    if (sel == 1) rdy2 = v;
    else rdy1 = v;
  endtask

  task automatic set_arm(input logic v);
    if (sel == 1) arm2 = v;
    else arm1 = v;
  endtask

  // Clocks until out_valid rises; optionally drives the ramp in=0,1,2,...
  task automatic run_until_valid(input bit ramp, input string tag);
    int j = 0;
    while (!o_valid && j < 80) begin
      if (ramp) in = W'(j);
      tick();
      j++;
    end
    chk({tag, "_valid_rise"}, o_valid, 1);
    last_steps = j;
  endtask

  // Accepts up to 'limit' samples; expected sample k = first + k*step.
  // stall selects the out_ready pattern 1,0,0,1 repeating.
  task automatic drain(input string tag, input int first, input int step,
                       input int limit, input bit stall);
    int got = 0;
    int cyc = 0;
    bit stalled = 0;
    logic signed [W-1:0] held = '0;
    logic r;
    while (got < limit && cyc < 100) begin
      r = stall ? (((cyc % 4) == 0) || ((cyc % 4) == 3)) : 1'b1;
      set_rdy(r);
      #1;
      if (stalled) chk({tag, "_stable"}, o_out, held);
      if (o_valid && r) begin
        $display("%s: sample %0d = %0d done=%0b", tag, got, o_out, o_done);
        chk($sformatf("%s_out%0d", tag, got), o_out, first + got * step);
        chk($sformatf("%s_done%0d", tag, got), o_done, (got == D - 1));
        got++;
      end else begin
        chk({tag, "_done_low"}, o_done, 0);
      end
      stalled = o_valid && !r;
      held = o_out;
      tick();
      cyc++;
    end
    chk({tag, "_count"}, got, limit);
    set_rdy(1'b0);
  endtask

  initial begin
    // ---- reset state ----
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_ov1", ov1, 0);     chk("rst_ov2", ov2, 0);
    chk("rst_busy1", busy1, 0); chk("rst_busy2", busy2, 0);
    chk("rst_done1", done1, 0); chk("rst_done2", done2, 0);
    chk("rst_out1", out1, 0);   chk("rst_out2", out2, 0);

    // ---- release: arm ignored on first edge, honoured on second ----
    sel = 0;
    rst_n = 1'b1;
    arm1 = 1'b1;
    in = '0;
    tick();
    chk("release_edge1_busy", busy1, 0);
    tick();
    chk("release_edge2_busy", busy1, 1);
    arm1 = 1'b0;

    // ---- ramp, DECIM=1: expect 7..14 ----
    run_until_valid(1, "ramp1");
    chk("ramp1_latency", (last_steps >= 16 && last_steps <= 17), 1);
    drain("ramp1", 7, 1, D, 0);
    chk("ramp1_busy_end", busy1, 0);
    chk("ramp1_valid_end", ov1, 0);

    // ---- ramp, DECIM=2: expect 4,6,...,18 (first >=10 at index 3) ----
    sel = 1;
    set_arm(1'b1);
    in = '0;
    tick();
    set_arm(1'b0);
    run_until_valid(1, "ramp2");
    chk("ramp2_latency", (last_steps >= 20 && last_steps <= 21), 1);
    drain("ramp2", 4, 2, D, 0);
    chk("ramp2_busy_end", busy2, 0);

    // ---- force trigger with in held at 0 ----
    sel = 0;
    in = '0;
    arm1 = 1'b1;
    tick();
    arm1 = 1'b0;
    repeat (6) tick();
    chk("force_wait_valid", ov1, 0);
    chk("force_wait_busy", busy1, 1);
    force_trig = 1'b1;
    tick();
    force_trig = 1'b0;
    run_until_valid(0, "force");
    drain("force", 0, 0, D, 0);
    chk("force_busy_end", busy1, 0);

    // ---- stalled drain, out_ready 1,0,0,1 ----
    arm1 = 1'b1;
    in = '0;
    tick();
    arm1 = 1'b0;
    run_until_valid(1, "stall");
    drain("stall", 7, 1, D, 1);
    chk("stall_busy_end", busy1, 0);

    // ---- reset midway through DRAIN, then a fresh capture ----
    arm1 = 1'b1;
    in = '0;
    tick();
    arm1 = 1'b0;
    run_until_valid(1, "abort");
    drain("abort", 7, 1, 3, 0);
    rst_n = 1'b0;
    #1;
    chk("abort_ov", ov1, 0);
    chk("abort_busy", busy1, 0);
    chk("abort_out", out1, 0);
    chk("abort_done", done1, 0);
    tick();
    tick();
    rst_n = 1'b1;
    arm1 = 1'b1;
    in = '0;
    tick();
    chk("rearm_edge1_busy", busy1, 0);
    tick();
    chk("rearm_edge2_busy", busy1, 1);
    arm1 = 1'b0;
    run_until_valid(1, "rearm");
    drain("rearm", 7, 1, D, 0);

    // ---- crossing during PRE is ignored; arm while busy is ignored ----
    arm1 = 1'b1;
    in = '0;
    tick();
    arm1 = 1'b0;
    in = 16'sd0;  tick();
    in = 16'sd20; tick();
    in = 16'sd5;  tick();
    repeat (8) tick();
    chk("precross_no_trig", ov1, 0);
    chk("precross_armed_busy", busy1, 1);
    arm1 = 1'b1;
    tick();
    arm1 = 1'b0;
    tick();
    chk("busy_arm_ignored_busy", busy1, 1);
    chk("busy_arm_ignored_valid", ov1, 0);
    force_trig = 1'b1;
    tick();
    force_trig = 1'b0;
    run_until_valid(0, "precross");
    drain("precross", 5, 0, D, 0);
    chk("precross_busy_end", busy1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
